fpu_dp_core: RTL and testbench

- Multi-cycle IEEE-754 double-precision floating-point unit: add, subtract, multiply and divide, with four rounding modes and status flags.
- Sits under the echo-canceller datapath; several instances run in parallel, and each is started with a one-shot `enable` and polled through `ready`.
- One operation in flight per instance.

---
 rtl/fpu_dp_core.sv | 369 ++++++++++++++++++++++++++++++++++++
 tb/tb_fpu_dp_core.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fpu_dp_core.sv
// Multi-cycle IEEE-754 binary64 add/sub/mul/div core with four rounding modes and status flags.
// Define FPU_STICKY_FLAGS_EN to make the status flags accumulate across operations until rst.
module fpu_dp_core #(
    parameter int DIV_ITER = 55
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  rmode,
    input  logic [2:0]  fpu_op,
    input  logic [63:0] opa,
    input  logic [63:0] opb,
    output logic [63:0] out,
    output logic        ready,
    output logic        underflow,
    output logic        overflow,
    output logic        inexact,
    output logic        exception,
    output logic        invalid
);

    localparam logic [2:0]  OP_ADD = 3'b000;
    localparam logic [2:0]  OP_SUB = 3'b001;
    localparam logic [2:0]  OP_MUL = 3'b010;
    localparam logic [2:0]  OP_DIV = 3'b011;
    localparam logic [63:0] QNAN   = 64'h7FF8_0000_0000_0000;
    localparam logic [7:0]  DIV_LAST = 8'(DIV_ITER - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_UNPACK, ST_EXEC, ST_NORM, ST_ROUND, ST_DONE
    } state_t;

    state_t state_r, state_nxt_s;

    logic [63:0] opa_r, opb_r;
    logic [2:0]  op_r;
    logic [1:0]  rmode_r;
    logic        sa_r, sb_r;
    logic [10:0] ea_r, eb_r;
    logic [52:0] ma_r, mb_r;
    logic        special_r, special_inv_r, special_dz_r;
    logic [63:0] special_val_r;
    logic [53:0] rem_r;
    logic [DIV_ITER-1:0] quo_r;
    logic [7:0]  cnt_r;
    logic        sign_r;
    logic [13:0] we_r;
    logic [107:0] wm_r;

    // Unpack signals
    logic [10:0] ua_exp_s, ub_exp_s;
    logic        za_s, zb_s, ia_s, ib_s, na_s, nb_s, usb_s, usm_s;
    logic [52:0] uma_s, umb_s;
    logic        sp_s, sp_inv_s, sp_dz_s;
    logic [63:0] sp_val_s;

    // Exec signals
    logic        a_big_s, s_big_s, zero_sign_s;
    logic [10:0] e_big_s, e_small_s, diff_s;
    logic [52:0] m_big_s, m_small_s;
    logic [6:0]  shamt_s;
    logic [111:0] ext_s;
    logic [55:0] small_al_s, big_al_s;
    logic [56:0] sum_s;
    logic [105:0] prod_s;
    logic        rem_ge_s;
    logic [53:0] rem_sub_s, rem_nxt_s;
    logic [DIV_ITER-1:0] quo_nxt_s;
    logic [107:0] exec_wm_s;
    logic [13:0] exec_we_s;
    logic        exec_sign_s;

    // Normalise / round signals
    logic [6:0]  lead_s, shl_s;
    logic [107:0] norm_wm_s;
    logic [13:0] norm_we_s;
    logic        g_s, r_s, st_s, up_s;
    logic [53:0] m_rnd_s;
    logic [13:0] exp_rnd_s;
    logic [51:0] frac_s;
    logic [63:0] res_s;
    logic        res_unf_s, res_ovf_s, res_inx_s, res_inv_s, res_dz_s;

    // Next-state logic; enable restarts from any state
    always_comb begin
        state_nxt_s = state_r;
        if (enable) begin
            state_nxt_s = ST_UNPACK;
        end else begin
            case (state_r)
                ST_IDLE:   state_nxt_s = ST_IDLE;
                ST_UNPACK: state_nxt_s = ST_EXEC;
                ST_EXEC: begin
                    if (op_r == OP_DIV && cnt_r != DIV_LAST) begin
                        state_nxt_s = ST_EXEC;
                    end else begin
                        state_nxt_s = ST_NORM;
                    end
                end
                ST_NORM:   state_nxt_s = ST_ROUND;
                ST_ROUND:  state_nxt_s = ST_DONE;
                ST_DONE:   state_nxt_s = ST_DONE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Field split and special-operand classification; denormals count as zero
    always_comb begin
        ua_exp_s = opa_r[62:52];
        ub_exp_s = opb_r[62:52];
        za_s  = (ua_exp_s == 11'd0);
        zb_s  = (ub_exp_s == 11'd0);
        ia_s  = (ua_exp_s == 11'h7FF) && (opa_r[51:0] == 52'd0);
        ib_s  = (ub_exp_s == 11'h7FF) && (opb_r[51:0] == 52'd0);
        na_s  = (ua_exp_s == 11'h7FF) && (opa_r[51:0] != 52'd0);
        nb_s  = (ub_exp_s == 11'h7FF) && (opb_r[51:0] != 52'd0);
        uma_s = za_s ? 53'd0 : {1'b1, opa_r[51:0]};
        umb_s = zb_s ? 53'd0 : {1'b1, opb_r[51:0]};
        usb_s = opb_r[63] ^ (op_r == OP_SUB);
        usm_s = opa_r[63] ^ opb_r[63];
        sp_s = 1'b0;
        sp_inv_s = 1'b0;
        sp_dz_s = 1'b0;
        sp_val_s = QNAN;
        if (op_r[2] || na_s || nb_s) begin
            sp_s = 1'b1;
            sp_inv_s = 1'b1;
        end else begin
            case (op_r)
                OP_ADD, OP_SUB: begin
                    if (ia_s && ib_s && (opa_r[63] != usb_s)) begin
                        sp_s = 1'b1; sp_inv_s = 1'b1;
                    end else if (ia_s) begin
                        sp_s = 1'b1; sp_val_s = {opa_r[63], 11'h7FF, 52'd0};
                    end else if (ib_s) begin
                        sp_s = 1'b1; sp_val_s = {usb_s, 11'h7FF, 52'd0};
                    end else begin
                        sp_s = 1'b0;
                    end
                end
                OP_MUL: begin
                    if ((ia_s && zb_s) || (za_s && ib_s)) begin
                        sp_s = 1'b1; sp_inv_s = 1'b1;
                    end else if (ia_s || ib_s) begin
                        sp_s = 1'b1; sp_val_s = {usm_s, 11'h7FF, 52'd0};
                    end else if (za_s || zb_s) begin
                        sp_s = 1'b1; sp_val_s = {usm_s, 63'd0};
                    end else begin
                        sp_s = 1'b0;
                    end
                end
                OP_DIV: begin
                    if ((za_s && zb_s) || (ia_s && ib_s)) begin
                        sp_s = 1'b1; sp_inv_s = 1'b1;
                    end else if (ia_s) begin
                        sp_s = 1'b1; sp_val_s = {usm_s, 11'h7FF, 52'd0};
                    end else if (zb_s) begin
                        sp_s = 1'b1; sp_dz_s = 1'b1; sp_val_s = {usm_s, 11'h7FF, 52'd0};
                    end else if (ib_s || za_s) begin
                        sp_s = 1'b1; sp_val_s = {usm_s, 63'd0};
                    end else begin
                        sp_s = 1'b0;
                    end
                end
                default: begin
                    sp_s = 1'b1; sp_inv_s = 1'b1;
                end
            endcase
        end
    end

    // Alignment, add/sub, multiply and one restoring-divide step
    always_comb begin
        a_big_s = ({ea_r, ma_r} >= {eb_r, mb_r});
        if (a_big_s) begin
            e_big_s = ea_r; e_small_s = eb_r; m_big_s = ma_r; m_small_s = mb_r; s_big_s = sa_r;
        end else begin
            e_big_s = eb_r; e_small_s = ea_r; m_big_s = mb_r; m_small_s = ma_r; s_big_s = sb_r;
        end
        diff_s     = e_big_s - e_small_s;
        shamt_s    = (diff_s > 11'd56) ? 7'd56 : diff_s[6:0];
        ext_s      = {m_small_s, 3'b000, 56'd0} >> shamt_s;
        small_al_s = {ext_s[111:57], ext_s[56] | (|ext_s[55:0])};
        big_al_s   = {m_big_s, 3'b000};
        if (sa_r == sb_r) begin
            sum_s = {1'b0, big_al_s} + {1'b0, small_al_s};
        end else begin
            sum_s = {1'b0, big_al_s} - {1'b0, small_al_s};
        end
        // An exact-zero sum is +0 except when rounding toward -inf
        zero_sign_s = (sa_r == sb_r) ? sa_r : (rmode_r == 2'b11);
        prod_s    = ma_r * mb_r;
        rem_ge_s  = (rem_r >= {1'b0, mb_r});
        rem_sub_s = rem_ge_s ? (rem_r - {1'b0, mb_r}) : rem_r;
        rem_nxt_s = rem_sub_s << 1;
        quo_nxt_s = {quo_r[DIV_ITER-2:0], rem_ge_s};
        case (op_r)
            OP_ADD, OP_SUB: begin
                exec_wm_s   = {sum_s, 51'd0};
                exec_we_s   = {3'b000, e_big_s};
                exec_sign_s = (sum_s == 57'd0) ? zero_sign_s : s_big_s;
            end
            OP_MUL: begin
                exec_wm_s   = {prod_s, 2'b00};
                exec_we_s   = {3'b000, ea_r} + {3'b000, eb_r} - 14'd1023;
                exec_sign_s = sa_r ^ sb_r;
            end
            OP_DIV: begin
                exec_wm_s   = (108'(quo_nxt_s) << (107 - DIV_ITER)) | {107'd0, (rem_sub_s != 54'd0)};
                exec_we_s   = {3'b000, ea_r} - {3'b000, eb_r} + 14'd1023;
                exec_sign_s = sa_r ^ sb_r;
            end
            default: begin
                exec_wm_s   = 108'd0;
                exec_we_s   = 14'd0;
                exec_sign_s = 1'b0;
            end
        endcase
    end

    // Leading-one normalisation: the hidden bit lands on wm bit 106
    always_comb begin
        lead_s = 7'd0;
        for (int i = 0; i < 108; i++) begin
            if (wm_r[i]) begin
                lead_s = 7'(i);
            end else begin
                lead_s = lead_s;
            end
        end
        shl_s = 7'd0;
        if (wm_r == 108'd0) begin
            norm_wm_s = wm_r;
            norm_we_s = we_r;
        end else if (lead_s == 7'd107) begin
            norm_wm_s = {1'b0, wm_r[107:2], wm_r[1] | wm_r[0]};
            norm_we_s = we_r + 14'd1;
        end else begin
            shl_s     = 7'd106 - lead_s;
            norm_wm_s = wm_r << shl_s;
            norm_we_s = we_r - {7'd0, shl_s};
        end
    end

    // Rounding, overflow/underflow resolution and final packing
    always_comb begin
        g_s  = wm_r[53];
        r_s  = wm_r[52];
        st_s = |wm_r[51:0];
        case (rmode_r)
            2'b00:   up_s = g_s & (r_s | st_s | wm_r[54]);
            2'b01:   up_s = 1'b0;
            2'b10:   up_s = ~sign_r & (g_s | r_s | st_s);
            2'b11:   up_s = sign_r & (g_s | r_s | st_s);
            default: up_s = 1'b0;
        endcase
        m_rnd_s   = {1'b0, wm_r[106:54]} + {53'd0, up_s};
        exp_rnd_s = we_r + {13'd0, m_rnd_s[53]};
        frac_s    = m_rnd_s[53] ? m_rnd_s[52:1] : m_rnd_s[51:0];
        res_unf_s = 1'b0;
        res_ovf_s = 1'b0;
        res_inx_s = 1'b0;
        res_inv_s = 1'b0;
        res_dz_s  = 1'b0;
        if (special_r) begin
            res_s     = special_val_r;
            res_inv_s = special_inv_r;
            res_dz_s  = special_dz_r;
        end else if (wm_r == 108'd0) begin
            res_s = {sign_r, 63'd0};
        end else if (!exp_rnd_s[13] && (exp_rnd_s >= 14'd2047)) begin
            res_ovf_s = 1'b1;
            res_inx_s = 1'b1;
            case (rmode_r)
                2'b10:   res_s = sign_r ? {1'b1, 11'h7FE, {52{1'b1}}} : {1'b0, 11'h7FF, 52'd0};
                2'b11:   res_s = sign_r ? {1'b1, 11'h7FF, 52'd0} : {1'b0, 11'h7FE, {52{1'b1}}};
                default: res_s = {sign_r, 11'h7FF, 52'd0};
            endcase
        end else if (exp_rnd_s[13] || (exp_rnd_s == 14'd0)) begin
            res_unf_s = 1'b1;
            res_inx_s = 1'b1;
            res_s     = {sign_r, 63'd0};
        end else begin
            res_inx_s = g_s | r_s | st_s;
            res_s     = {sign_r, exp_rnd_s[10:0], frac_s};
        end
    end

    // Datapath registers, advanced one stage per FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_r <= 64'd0; opb_r <= 64'd0; op_r <= 3'd0; rmode_r <= 2'd0;
            sa_r <= 1'b0; sb_r <= 1'b0; ea_r <= 11'd0; eb_r <= 11'd0;
            ma_r <= 53'd0; mb_r <= 53'd0;
            special_r <= 1'b0; special_inv_r <= 1'b0; special_dz_r <= 1'b0;
            special_val_r <= 64'd0;
            rem_r <= 54'd0; quo_r <= '0; cnt_r <= 8'd0;
            sign_r <= 1'b0; we_r <= 14'd0; wm_r <= 108'd0;
        end else if (enable) begin
            opa_r <= opa; opb_r <= opb; op_r <= fpu_op; rmode_r <= rmode;
        end else begin
            case (state_r)
                ST_UNPACK: begin
                    sa_r <= opa_r[63]; sb_r <= usb_s;
                    ea_r <= za_s ? 11'd0 : ua_exp_s;
                    eb_r <= zb_s ? 11'd0 : ub_exp_s;
                    ma_r <= uma_s; mb_r <= umb_s;
                    special_r <= sp_s; special_inv_r <= sp_inv_s; special_dz_r <= sp_dz_s;
                    special_val_r <= sp_val_s;
                    rem_r <= {1'b0, uma_s}; quo_r <= '0; cnt_r <= 8'd0;
                end
                ST_EXEC: begin
                    rem_r <= rem_nxt_s; quo_r <= quo_nxt_s; cnt_r <= cnt_r + 8'd1;
                    wm_r <= exec_wm_s; we_r <= exec_we_s; sign_r <= exec_sign_s;
                end
                ST_NORM: begin
                    wm_r <= norm_wm_s; we_r <= norm_we_s;
                end
                default: begin
                    wm_r <= wm_r;
                end
            endcase
        end
    end

    // Result and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= 64'd0; ready <= 1'b0;
            underflow <= 1'b0; overflow <= 1'b0; inexact <= 1'b0;
            exception <= 1'b0; invalid <= 1'b0;
        end else if (enable) begin
            ready <= 1'b0;
`ifndef FPU_STICKY_FLAGS_EN
            underflow <= 1'b0; overflow <= 1'b0; inexact <= 1'b0;
            exception <= 1'b0; invalid <= 1'b0;
`endif
        end else if (state_r == ST_ROUND) begin
            out   <= res_s;
            ready <= 1'b1;
`ifdef FPU_STICKY_FLAGS_EN
            underflow <= underflow | res_unf_s;
            overflow  <= overflow | res_ovf_s;
            inexact   <= inexact | res_inx_s;
            invalid   <= invalid | res_inv_s;
            exception <= exception | res_inv_s | res_ovf_s | res_unf_s | res_dz_s;
`else
            underflow <= res_unf_s;
            overflow  <= res_ovf_s;
            inexact   <= res_inx_s;
            invalid   <= res_inv_s;
            exception <= res_inv_s | res_ovf_s | res_unf_s | res_dz_s;
`endif
        end else begin
            ready <= ready;
        end
    end

endmodule

// File: tb/tb_fpu_dp_core.sv
// Directed scoreboard bench for fpu_dp_core: results, flags, handshake latency and async reset.
module tb_fpu_dp_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  rmode;
    logic [2:0]  fpu_op;
    logic [63:0] opa, opb;
    logic [63:0] out;
    logic        ready, underflow, overflow, inexact, exception, invalid;
    logic [4:0]  flags;

    // flags = {invalid, exception, inexact, overflow, underflow}
    assign flags = {invalid, exception, inexact, overflow, underflow};

    fpu_dp_core #(.DIV_ITER(55)) dut (
        .clk(clk), .rst(rst), .enable(enable), .rmode(rmode), .fpu_op(fpu_op),
        .opa(opa), .opb(opb), .out(out), .ready(ready), .underflow(underflow),
        .overflow(overflow), .inexact(inexact), .exception(exception), .invalid(invalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic [4:0]  flg;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int errors = 0;
    int checks = 0;

    task automatic run_op(input string tag, input logic [2:0] op, input logic [1:0] rm,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input logic [4:0] exp_flg, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        opa = a; opb = b; fpu_op = op; rmode = rm; enable = 1'b1;
        e.tag = tag; e.res = exp_res; e.flg = exp_flg; e.lat = lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        enable = 1'b0;
        opa = ~a; opb = ~b; fpu_op = 3'b111; rmode = ~rm;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready && n < lat + 6);
        e = sb_q.pop_front();
        checks++;
        assert (ready === 1'b1 && n == e.lat) else begin
            errors++;
            $error("FAIL %s_latency: ready=%0b at edge %0d, expected ready at edge %0d", e.tag, ready, n, e.lat);
        end
        checks++;
        assert (out === e.res) else begin
            errors++;
            $error("FAIL %s_out: got %h expected %h", e.tag, out, e.res);
        end
        checks++;
        assert (flags === e.flg) else begin
            errors++;
            $error("FAIL %s_flags: got %b expected %b", e.tag, flags, e.flg);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; rmode = 2'b00; fpu_op = 3'b000;
        opa = 64'd0; opb = 64'd0;
        #12;
        checks++;
        assert ({out, ready, flags} === 70'd0) else begin
            errors++;
            $error("FAIL reset_state: out=%h ready=%b flags=%b expected all zero", out, ready, flags);
        end
        @(negedge clk);
        rst = 1'b0;

        run_op("add_1p2",    3'b000, 2'b00, 64'h3FF0000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 4);
        run_op("mul_1p5x2",  3'b010, 2'b00, 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 5'b00000, 4);
        run_op("sub_zero",   3'b001, 2'b00, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h0000000000000000, 5'b00000, 4);
        run_op("sub_zero_m", 3'b001, 2'b11, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h8000000000000000, 5'b00000, 4);
        run_op("div_3by2",   3'b011, 2'b00, 64'h4008000000000000, 64'h4000000000000000, 64'h3FF8000000000000, 5'b00000, 58);
        run_op("rnd_rne",    3'b000, 2'b00, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000000, 5'b00100, 4);
        run_op("rnd_rup",    3'b000, 2'b10, 64'h3FF0000000000000, 64'h3CA0000000000000, 64'h3FF0000000000001, 5'b00100, 4);
        run_op("div_by0",    3'b011, 2'b00, 64'h3FF0000000000000, 64'h0000000000000000, 64'h7FF0000000000000, 5'b01000, 58);
        run_op("div_0by0",   3'b011, 2'b00, 64'h0000000000000000, 64'h0000000000000000, 64'h7FF8000000000000, 5'b11000, 58);
        run_op("mul_ovf",    3'b010, 2'b00, 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 5'b01110, 4);
        run_op("add_nan",    3'b000, 2'b00, 64'h7FF0000000000001, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b11000, 4);
        run_op("illegal_op", 3'b100, 2'b00, 64'h3FF0000000000000, 64'h3FF0000000000000, 64'h7FF8000000000000, 5'b11000, 4);
        run_op("inf_plus_1", 3'b000, 2'b00, 64'h7FF0000000000000, 64'h3FF0000000000000, 64'h7FF0000000000000, 5'b00000, 4);
        run_op("inf_m_inf",  3'b001, 2'b00, 64'h7FF0000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 5'b11000, 4);

        // Abort a divide with an asynchronous reset pulse between clock edges
        @(negedge clk);
        opa = 64'h4008000000000000; opb = 64'h4000000000000000; fpu_op = 3'b011; rmode = 2'b00; enable = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        assert (out === 64'd0 && ready === 1'b0 && flags === 5'd0) else begin
            errors++;
            $error("FAIL async_reset: out=%h ready=%b flags=%b expected 0/0/0", out, ready, flags);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        checks++;
        assert (ready === 1'b0 && out === 64'd0) else begin
            errors++;
            $error("FAIL abort_no_result: ready=%b out=%h expected 0 and 0", ready, out);
        end
        run_op("div_after_rst", 3'b011, 2'b00, 64'h4008000000000000, 64'h4000000000000000, 64'h3FF8000000000000, 5'b00000, 58);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
